// File: rtl/sumador_serie_pkg.sv
// Shared definitions for the bit-serial adder/subtractor: FSM state encoding.
package sumador_serie_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/celda_suma.sv
// Combinational 1-bit full-adder cell reused every clock by the serial adder.
module celda_suma (
    input  logic xi,
    input  logic yi,
    input  logic ci,
    output logic Si,
    output logic Co
);

    assign Si = xi ^ yi ^ ci;
    assign Co = (xi & yi) | (xi & ci) | (yi & ci);

endmodule

// File: rtl/sumador_serie.sv
// Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop, LSB first,
// WIDTH cycles per operation with a one-cycle done pulse.
module sumador_serie
    import sumador_serie_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic             cin,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    output logic [WIDTH-1:0] s,
    output logic             co,
    output logic             ovf,
    output logic             busy,
    output logic             done
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] a_q, b_q, shadow_q, shadow_d, s_q;
    logic             carry_q, co_q, ovf_q, busy_q, done_q;
    logic             cell_s, cell_co;
    logic             accept, step, last;

    celda_suma u_celda (
        .xi (a_q[0]),
        .yi (b_q[0]),
        .ci (carry_q),
        .Si (cell_s),
        .Co (cell_co)
    );

    assign accept = start && (state_q == ST_IDLE || state_q == ST_DONE);
    assign step   = (state_q == ST_RUN);
    assign last   = step && (cnt_q == LAST);

    // Sum bits enter at the MSB so after WIDTH shifts the word is aligned.
    assign shadow_d = (shadow_q >> 1) | (WIDTH'(cell_s) << (WIDTH - 1));

    // Operand datapath: no reset needed, always reloaded on an accepted start.
    always_ff @(posedge clk) begin
        if (accept) begin
            a_q     <= x;
            b_q     <= sub ? ~y : y;
            carry_q <= sub ? 1'b1 : cin;
        end else if (step) begin
            a_q      <= a_q >> 1;
            b_q      <= b_q >> 1;
            carry_q  <= cell_co;
            shadow_q <= shadow_d;
        end
    end

    // Control FSM with registered outputs; carry_q at the last edge is the carry into the MSB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            s_q     <= '0;
            co_q    <= 1'b0;
            ovf_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    state_q <= ST_IDLE;
                    if (accept) begin
                        state_q <= ST_RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
                ST_RUN: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (last) begin
                        state_q <= ST_DONE;
                        cnt_q   <= '0;
                        s_q     <= shadow_d;
                        co_q    <= cell_co;
                        ovf_q   <= carry_q ^ cell_co;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign s    = s_q;
    assign co   = co_q;
    assign ovf  = ovf_q;
    assign busy = busy_q;
    assign done = done_q;

endmodule

// File: tb/tb_sumador_serie.sv
// Directed bench for sumador_serie: WIDTH=8 arithmetic/protocol cases and WIDTH=1 full-adder table.
module tb_sumador_serie;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, sub8, cin8;
    logic [7:0] x8, y8, s8;
    logic       co8, ovf8, busy8, done8;
    logic       start1, sub1, cin1;
    logic [0:0] x1, y1, s1;
    logic       co1, ovf1, busy1, done1;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    sumador_serie #(.WIDTH(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .sub(sub8), .cin(cin8),
        .x(x8), .y(y8), .s(s8), .co(co8), .ovf(ovf8), .busy(busy8), .done(done8)
    );

    sumador_serie #(.WIDTH(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .sub(sub1), .cin(cin1),
        .x(x1), .y(y1), .s(s1), .co(co1), .ovf(ovf1), .busy(busy1), .done(done1)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse start for one cycle; returns just after the accepting edge.
    task automatic launch8(input logic [7:0] xv, input logic [7:0] yv, input logic subv, input logic cinv);
        @(negedge clk);
        x8 = xv; y8 = yv; sub8 = subv; cin8 = cinv; start8 = 1'b1;
        @(posedge clk); #1;
        start8 = 1'b0;
    endtask

    task automatic op8(input logic [7:0] xv, input logic [7:0] yv, input logic subv,
                       input logic cinv, output int lat);
        launch8(xv, yv, subv, cinv);
        lat = 0;
        while (!done8 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic op1(input logic xv, input logic yv, input logic cinv, output int lat);
        @(negedge clk);
        x1 = xv; y1 = yv; sub1 = 1'b0; cin1 = cinv; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        lat = 0;
        while (!done1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    initial begin
        int lat;
        int ndone;
        logic [2:0] v;
        logic exp_s, exp_co;

        rst_n = 1'b0;
        start8 = 1'b0; sub8 = 1'b0; cin8 = 1'b0; x8 = '0; y8 = '0;
        start1 = 1'b0; sub1 = 1'b0; cin1 = 1'b0; x1 = '0; y1 = '0;
        repeat (2) @(posedge clk);
        #1;
        check("rst_s",    32'(s8),    32'h0);
        check("rst_co",   32'(co8),   32'h0);
        check("rst_ovf",  32'(ovf8),  32'h0);
        check("rst_busy", 32'(busy8), 32'h0);
        check("rst_done", 32'(done8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Basic add, latency and done width
        op8(8'h0F, 8'h01, 1'b0, 1'b0, lat);
        check("add1_lat", 32'(lat), 32'd8);
        check("add1_s",   32'(s8),  32'h10);
        check("add1_co",  32'(co8), 32'h0);
        check("add1_ovf", 32'(ovf8), 32'h0);
        @(posedge clk); #1;
        check("add1_done_pulse", 32'(done8), 32'h0);

        op8(8'hFF, 8'h01, 1'b0, 1'b0, lat);
        check("add2_s",   32'(s8),   32'h00);
        check("add2_co",  32'(co8),  32'h1);
        check("add2_ovf", 32'(ovf8), 32'h0);

        // Back-to-back: started while in DONE
        op8(8'h7F, 8'h01, 1'b0, 1'b0, lat);
        check("add3_lat", 32'(lat),  32'd8);
        check("add3_s",   32'(s8),   32'h80);
        check("add3_co",  32'(co8),  32'h0);
        check("add3_ovf", 32'(ovf8), 32'h1);

        op8(8'h10, 8'h20, 1'b0, 1'b1, lat);
        check("addcin_s",  32'(s8),  32'h31);
        check("addcin_co", 32'(co8), 32'h0);

        op8(8'h05, 8'h07, 1'b1, 1'b1, lat);
        check("sub1_s",   32'(s8),   32'hFE);
        check("sub1_co",  32'(co8),  32'h0);
        check("sub1_ovf", 32'(ovf8), 32'h0);

        op8(8'h80, 8'h01, 1'b1, 1'b0, lat);
        check("sub2_s",   32'(s8),   32'h7F);
        check("sub2_co",  32'(co8),  32'h1);
        check("sub2_ovf", 32'(ovf8), 32'h1);
        @(posedge clk); #1;

        // start during RUN is ignored
        launch8(8'h10, 8'h20, 1'b0, 1'b0);
        check("ign_busy_0", 32'(busy8), 32'h1);
        ndone = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (k == 3) begin
                x8 = 8'hAA; start8 = 1'b1;
            end else begin
                start8 = 1'b0;
            end
            @(posedge clk); #1;
            check($sformatf("ign_busy_%0d", k), 32'(busy8), (k < 8) ? 32'h1 : 32'h0);
            if (done8) ndone++;
        end
        check("ign_ndone", 32'(ndone), 32'd1);
        check("ign_s",     32'(s8),    32'h30);

        // Reset in the middle of RUN
        launch8(8'h11, 8'h22, 1'b0, 1'b0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("mid_rst_s",    32'(s8),    32'h0);
        check("mid_rst_co",   32'(co8),   32'h0);
        check("mid_rst_busy", 32'(busy8), 32'h0);
        check("mid_rst_done", 32'(done8), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0;
        for (int k = 0; k < 10; k++) begin
            @(posedge clk); #1;
            if (done8 || busy8) ndone++;
        end
        check("mid_rst_quiet", 32'(ndone), 32'd0);
        op8(8'h03, 8'h04, 1'b0, 1'b0, lat);
        check("after_rst_lat", 32'(lat), 32'd8);
        check("after_rst_s",   32'(s8),  32'h07);

        // WIDTH=1 behaves as the full-adder cell
        for (int i = 0; i < 8; i++) begin
            v = 3'(i);
            exp_s  = v[2] ^ v[1] ^ v[0];
            exp_co = (v[2] & v[1]) | (v[2] & v[0]) | (v[1] & v[0]);
            op1(v[2], v[1], v[0], lat);
            check($sformatf("fa_lat_%0d", i), 32'(lat),  32'd1);
            check($sformatf("fa_s_%0d", i),   32'(s1),   32'(exp_s));
            check($sformatf("fa_co_%0d", i),  32'(co1),  32'(exp_co));
            check($sformatf("fa_ovf_%0d", i), 32'(ovf1), 32'(v[0] ^ exp_co));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
